// File: rtl/asyn_fifo_pkg.sv
// rtl/asyn_fifo_pkg.sv - default asyn_fifo widths and Gray-code helpers shared by both pointer controllers
package asyn_fifo_pkg;

   localparam int ASYN_ADDR_WIDTH = 4;
   localparam int ASYN_DATA_WIDTH = 32;
   localparam int GRAY_MAX_W      = 32;

   // Callers zero-extend into GRAY_MAX_W and cast the result back to their own pointer width.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_ctrl_fwft_if.sv
// rtl/rd_ctrl_fwft_if.sv - first-word-fall-through read stream between rd_ctrl_fwft and its consumer
interface rd_ctrl_fwft_if
   import asyn_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = ASYN_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  rready;

   modport master (output rdata, output rvalid, input rready);
   modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/rd_ctrl_fwft_out_buf.sv
// rtl/rd_ctrl_fwft_out_buf.sv - rd_out_buf, 2-entry head+skid buffer turning RAM read data into an FWFT stream
module rd_out_buf
   import asyn_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = ASYN_DATA_WIDTH
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic [1:0]            bcnt_q;
   logic                  pop;

   assign pop       = out_valid & out_ready;
   assign out_valid = (bcnt_q != 2'd0);
   assign out_data  = head_q;
   assign count     = bcnt_q;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         head_q <= '0;
         skid_q <= '0;
         bcnt_q <= 2'd0;
      end else if (pop) begin
         // On a pop the head refills from the skid word first, so order is preserved.
         if (bcnt_q == 2'd2) begin
            head_q <= skid_q;
            if (in_valid) begin
               skid_q <= in_data;
            end
         end else if (in_valid) begin
            head_q <= in_data;
         end
         if (!in_valid) begin
            bcnt_q <= bcnt_q - 2'd1;
         end
      end else if (in_valid) begin
         if (bcnt_q == 2'd0) begin
            head_q <= in_data;
         end else begin
            skid_q <= in_data;
         end
         bcnt_q <= bcnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/rd_ctrl_fwft.sv
// rtl/rd_ctrl_fwft.sv - asyn_fifo read-side pointer/empty controller with FWFT output; RD_LEVEL_EN adds rlevel/ralmost_empty
module rd_ctrl_fwft
   import asyn_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = ASYN_ADDR_WIDTH,
   parameter int DATA_WIDTH = ASYN_DATA_WIDTH,
   parameter int AE_THRESH  = 2
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  ren,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   rd_ctrl_fwft_if.master        rd,
   output logic                  rempty,
   output logic [ADDR_WIDTH:0]   rlevel,
   output logic                  ralmost_empty
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] rbin_next;
   logic [PTR_W-1:0] rgray_next;
   logic             inflight;
   logic [1:0]       bcnt;
   logic             pop;
   logic [2:0]       occ_after_pop;

   assign pop = rd.rvalid & rd.rready;

   // Only fetch when the word still fits after this cycle's pop; buffer plus in-flight never exceeds 2.
   assign occ_after_pop = {1'b0, bcnt} + {2'b00, inflight} - {2'b00, pop};
   assign ren           = ~rempty & (occ_after_pop < 3'd2);

   assign rbin_next  = rbin + PTR_W'(ren);
   assign rgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_next)));
   assign raddr      = rbin[ADDR_WIDTH-1:0];

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin     <= '0;
         rptr     <= '0;
         rempty   <= 1'b1;
         inflight <= 1'b0;
      end else begin
         rbin     <= rbin_next;
         rptr     <= rgray_next;
         rempty   <= (rgray_next == rq2_wptr);
         inflight <= ren;
      end
   end

   rd_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .in_valid  (inflight),
      .in_data   (rdata_mem),
      .out_valid (rd.rvalid),
      .out_ready (rd.rready),
      .out_data  (rd.rdata),
      .count     (bcnt)
   );

`ifdef RD_LEVEL_EN
   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] level_next;

   assign wbin       = PTR_W'(gray2bin(GRAY_MAX_W'(rq2_wptr)));
   assign level_next = wbin - rbin_next;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rlevel        <= '0;
         ralmost_empty <= 1'b1;
      end else begin
         rlevel        <= level_next;
         ralmost_empty <= (level_next <= PTR_W'(AE_THRESH));
      end
   end
`else
   assign rlevel        = '0;
   assign ralmost_empty = rempty;
`endif

endmodule

// File: tb/tb_rd_ctrl_fwft.sv
// tb/tb_rd_ctrl_fwft.sv - scoreboard bench for rd_ctrl_fwft; level checks follow RD_LEVEL_EN
`timescale 1ns/1ps
module tb_rd_ctrl_fwft;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int PW = AW + 1;

   logic          rclk = 1'b0;
   logic          rrst_n = 1'b0;
   logic [PW-1:0] rq2_wptr = '0;
   logic [PW-1:0] rptr;
   logic [AW-1:0] raddr;
   logic          ren;
   logic [DW-1:0] rdata_mem;
   logic          rempty;
   logic [PW-1:0] rlevel;
   logic          ralmost_empty;

   rd_ctrl_fwft_if #(.DATA_WIDTH(DW)) rd_if ();

   rd_ctrl_fwft #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .AE_THRESH  (2)
   ) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rq2_wptr      (rq2_wptr),
      .rptr          (rptr),
      .raddr         (raddr),
      .ren           (ren),
      .rdata_mem     (rdata_mem),
      .rd            (rd_if),
      .rempty        (rempty),
      .rlevel        (rlevel),
      .ralmost_empty (ralmost_empty)
   );

   always #5 rclk = ~rclk;

   logic [DW-1:0] mem [0:15];
   always @(posedge rclk) begin
      if (ren) rdata_mem <= mem[raddr];
   end

   int            total = 0;
   int            bad = 0;
   int            wcnt = 0;
   logic [DW-1:0] exp_q [$];
   logic          hold_v = 1'b0;
   logic [DW-1:0] hold_d = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] g(input int n);
      logic [4:0] v;
      v = n[4:0];
      return v ^ (v >> 1);
   endfunction

   function automatic logic [DW-1:0] word(input int k);
      return 32'hC0DE_0000 + 32'(k);
   endfunction

   // Monitor: pops the scoreboard on every handshake and checks stall/ordering rules.
   always @(negedge rclk) begin
      if (!rrst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("valid_hold", 32'(rd_if.rvalid), 32'd1);
            chk("data_hold", rd_if.rdata, hold_d);
         end
         if (rd_if.rvalid && rd_if.rready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %0h expected no word", rd_if.rdata);
            end else begin
               chk("data", rd_if.rdata, exp_q.pop_front());
            end
         end
         hold_v = rd_if.rvalid & ~rd_if.rready;
         hold_d = rd_if.rdata;
         total++;
         if (32'(dut.bcnt) + 32'(dut.inflight) > 32'd2) begin
            bad++;
            $display("FAIL occupancy: got %0d expected <=2", 32'(dut.bcnt) + 32'(dut.inflight));
         end
         total++;
         if (ren && rempty) begin
            bad++;
            $display("FAIL ren_when_empty: got ren=1 expected ren=0");
         end
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      rd_if.rready = 1'b0;
      rq2_wptr = '0;
      wcnt = 0;
      exp_q.delete();
      repeat (2) tick();
      rrst_n = 1'b1;
      tick();
   endtask

   task automatic write_words(input int n);
      for (int k = 0; k < n; k++) begin
         mem[4'((wcnt + k) % 16)] = word(wcnt + k);
         exp_q.push_back(word(wcnt + k));
      end
      wcnt += n;
      rq2_wptr = g(wcnt);
   endtask

   task automatic drain(input string name, input int budget);
      int c;
      c = 0;
      while (!(exp_q.size() == 0 && rempty && !rd_if.rvalid && !dut.inflight) && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ren_n, ren_first, ren_last, v_n, v_first, v_last, found;
      rd_if.rready = 1'b0;

      // 1: idle after reset
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge rclk);
         chk("t1_rempty", 32'(rempty), 32'd1);
         chk("t1_rvalid", 32'(rd_if.rvalid), 32'd0);
         chk("t1_ren", 32'(ren), 32'd0);
         chk("t1_rptr", 32'(rptr), 32'd0);
      end
      tick();

      // 2: single word, consumer stalled
      write_words(1);
      tick();
      ren_n = 0; ren_first = -1; v_first = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge rclk);
         if (i == 0) chk("t2_rempty_fall", 32'(rempty), 32'd0);
         if (ren) begin
            ren_n++;
            if (ren_first < 0) ren_first = i;
            chk("t2_raddr", 32'(raddr), 32'd0);
         end
         if (rd_if.rvalid && v_first < 0) v_first = i;
      end
      chk("t2_ren_pulses", 32'(ren_n), 32'd1);
      chk("t2_latency", 32'(v_first - ren_first), 32'd2);
      @(posedge rclk); #1;
      rd_if.rready = 1'b1;
      tick();
      rd_if.rready = 1'b0;
      @(negedge rclk);
      chk("t2_rvalid_after_pop", 32'(rd_if.rvalid), 32'd0);
      chk("t2_left", 32'(exp_q.size()), 32'd0);

      // 3: 16-word burst, rready held high
      do_reset();
      rd_if.rready = 1'b1;
      write_words(16);
      ren_n = 0; ren_first = -1; ren_last = -1; v_n = 0; v_first = -1; v_last = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge rclk);
         if (ren) begin
            chk("t3_raddr", 32'(raddr), 32'(ren_n % 16));
            ren_n++;
            if (ren_first < 0) ren_first = i;
            ren_last = i;
         end
         if (rd_if.rvalid) begin
            v_n++;
            if (v_first < 0) v_first = i;
            v_last = i;
         end
      end
      chk("t3_ren_count", 32'(ren_n), 32'd16);
      chk("t3_ren_span", 32'(ren_last - ren_first), 32'd15);
      chk("t3_valid_count", 32'(v_n), 32'd16);
      chk("t3_valid_span", 32'(v_last - v_first), 32'd15);
      chk("t3_rempty", 32'(rempty), 32'd1);
      chk("t3_rptr", 32'(rptr), 32'b11000);
      chk("t3_left", 32'(exp_q.size()), 32'd0);

      // 4: 16 words, rready toggling
      do_reset();
      write_words(16);
      for (int i = 0; i < 80; i++) begin
         rd_if.rready = (i % 2 == 0);
         tick();
      end
      rd_if.rready = 1'b0;
      chk("t4_left", 32'(exp_q.size()), 32'd0);
      chk("t4_rempty", 32'(rempty), 32'd1);
      chk("t4_rptr", 32'(rptr), 32'b11000);

      // 5: 40 words across the pointer wrap
      do_reset();
      rd_if.rready = 1'b1;
      write_words(16);
      drain("t5a", 60);
      chk("t5_rptr16", 32'(rptr), 32'b11000);
      write_words(16);
      drain("t5b", 60);
      chk("t5_rptr32", 32'(rptr), 32'b00000);
      chk("t5_rempty32", 32'(rempty), 32'd1);
      write_words(8);
      tick();
      @(negedge rclk);
      chk("t5_rempty_fall40", 32'(rempty), 32'd0);
      drain("t5c", 40);
      chk("t5_rptr40", 32'(rptr), 32'b01100);
      rd_if.rready = 1'b0;

      // 6: asynchronous reset mid-transfer
      do_reset();
      rd_if.rready = 1'b1;
      write_words(4);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         #2;
         if (rd_if.rvalid && ren) found = 1;
      end
      chk("t6_found_busy", 32'(found), 32'd1);
      exp_q.delete();
      rrst_n = 1'b0;
      #1;
      chk("t6_rempty", 32'(rempty), 32'd1);
      chk("t6_rvalid", 32'(rd_if.rvalid), 32'd0);
      chk("t6_ren", 32'(ren), 32'd0);
      chk("t6_rptr", 32'(rptr), 32'd0);
      chk("t6_raddr", 32'(raddr), 32'd0);
      chk("t6_rdata", rd_if.rdata, 32'd0);

      // 6b: level / almost-empty with three words waiting
      do_reset();
      @(negedge rclk);
      chk("t6b_ae_reset", 32'(ralmost_empty), 32'd1);
      chk("t6b_level_reset", 32'(rlevel), 32'd0);
      tick();
      write_words(3);
      tick();
      @(negedge rclk);
`ifdef RD_LEVEL_EN
      chk("t6b_level3", 32'(rlevel), 32'd3);
      chk("t6b_ae3", 32'(ralmost_empty), 32'd0);
`else
      chk("t6b_level3", 32'(rlevel), 32'd0);
      chk("t6b_ae3", 32'(ralmost_empty), 32'd0);
`endif
      tick();
      @(negedge rclk);
`ifdef RD_LEVEL_EN
      chk("t6b_level2", 32'(rlevel), 32'd2);
      chk("t6b_ae2", 32'(ralmost_empty), 32'd1);
`else
      chk("t6b_level2", 32'(rlevel), 32'd0);
      chk("t6b_ae2", 32'(ralmost_empty), 32'd0);
`endif
      tick();
      rd_if.rready = 1'b1;
      drain("t6b", 40);
      rd_if.rready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
